// File: rtl/median_column_feeder_if.sv
// median_column_feeder_if: raster pixel input and filter-side column output of the median column feeder
interface median_column_feeder_if;
   logic [7:0] i_pix;
   logic       i_valid;
   logic       i_sof;
   logic       o_ready;
   logic [7:0] o_data;
   logic       o_en1;
   logic       o_en2;
   logic       o_med_valid;
   logic       o_frame_done;
   modport master (
      output i_pix, i_valid, i_sof,
      input  o_ready, o_data, o_en1, o_en2, o_med_valid, o_frame_done
   );
   modport slave (
      input  i_pix, i_valid, i_sof,
      output o_ready, o_data, o_en1, o_en2, o_med_valid, o_frame_done
   );
endinterface

// File: rtl/median_column_feeder.sv
// median_column_feeder: serialises 3-pixel raster columns for a 3x3 median filter; BORDER_REPLICATE_EN replicates border rows instead of zero-filling
module median_column_feeder #(
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480,
   parameter int MED_LAT = 4
) (
   input logic clk,
   input logic rst_n,
   median_column_feeder_if.slave io
);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   typedef enum logic [1:0] {IDLE, S0, S1, S2} state_t;
   state_t state, state_nx;
   logic [XW-1:0] x, xl, px;
   logic [YW-1:0] y, py;
   logic [7:0] pix, top, mid, top_nx, mid_nx, data_q;
   logic [7:0] lb0 [IMG_W];
   logic [7:0] lb1 [IMG_W];
   logic [MED_LAT-1:0] chain;
   logic tag, last, ready, accept, en2;
   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      ready = state == IDLE || state == S2;
      accept = io.i_valid && ready;
      state_nx = state == S0 ? S1 : state == S1 ? S2 : accept ? S0 : IDLE;
      en2 = state == S2 && rst_n;
      io.o_ready = ready;
      io.o_en1 = state != IDLE;
      io.o_en2 = en2;
      io.o_data = state == S0 ? top : state == S1 ? mid : state == S2 ? pix : data_q;
      io.o_med_valid = chain[MED_LAT-1];
      io.o_frame_done = en2 && last;
   end
   // a start-of-frame pixel always lands at (0,0), whatever the counters say
   always_comb begin
      px = io.i_sof ? '0 : x;
      py = io.i_sof ? '0 : y;
`ifdef BORDER_REPLICATE_EN
      top_nx = py == '0 ? io.i_pix : py == YW'(1) ? lb0[px] : lb1[px];
      mid_nx = py == '0 ? io.i_pix : lb0[px];
`else
      top_nx = py < YW'(2) ? 8'h00 : lb1[px];
      mid_nx = py == '0 ? 8'h00 : lb0[px];
`endif
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         x <= '0;
         y <= '0;
         data_q <= '0;
         chain <= '0;
      end else begin
         if (accept) begin
            pix <= io.i_pix;
            top <= top_nx;
            mid <= mid_nx;
            xl <= px;
            tag <= px >= XW'(2) && py >= YW'(2);
            last <= px == XW'(IMG_W-1) && py == YW'(IMG_H-1);
            x <= px == XW'(IMG_W-1) ? '0 : px + 1'b1;
            y <= px == XW'(IMG_W-1) ? (py == YW'(IMG_H-1) ? '0 : py + 1'b1) : py;
         end
         if (en2) begin
            data_q <= pix;
            chain <= MED_LAT'({chain, tag});
         end
      end
   // line buffers are written only when the column completes, so an aborted column leaves them untouched
   always_ff @(posedge clk)
      if (en2) begin
         lb1[xl] <= mid;
         lb0[xl] <= pix;
      end
endmodule

// File: doc/median_column_feeder.md
Name: median_column_feeder

Overview:
- Upstream neighbour of the 3x3 median filter.
- Accepts raster-order 8-bit pixels and keeps the previous two image lines in on-chip line buffers.
- For every accepted pixel it serialises one 3-pixel column onto the filter's pixel input: row y-2, then row y-1, then row y.
- Drives the filter's shift enable (en1) and capture enable (en2), plus a window-valid tag delayed to align with the filter's median output.

Parameters:
- IMG_W, 640, pixels per line (>=3); also line-buffer depth.
- IMG_H, 480, lines per frame (>=3).
- MED_LAT, 4, number of en2 pulses between a column capture and the filter's median output for the window that column completes.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- i_pix  in  8  raster input pixel.
- i_valid  in  1  i_pix valid.
- i_sof  in  1  start of frame; qualified by i_valid.
- o_ready  out  1  block accepts i_pix this cycle when i_valid & o_ready.
- o_data  out  8  serial column pixel to the filter's pixel input.
- o_en1  out  1  filter shift enable.
- o_en2  out  1  filter capture/pipeline-advance enable.
- o_med_valid  out  1  filter median output this cycle is a full in-frame window.
- o_frame_done  out  1  one-cycle pulse after the last pixel of a frame is emitted.

Behaviour:
- Clock and reset: one clock clk; reset rst_n is synchronous and active-low.
- FSM states:
  - IDLE -> S0 on accept.
  - S0 -> S1 -> S2 unconditionally.
  - S2 -> S0 on accept, else IDLE.
- o_ready = 1 in IDLE and S2, 0 in S0/S1. Peak throughput is 1 pixel per 3 cycles.
- On accept, latch pix=i_pix, col x, row y, top=lb1[x], mid=lb0[x] into holding registers. Line-buffer reads are from the pre-write contents.
- Per-state outputs:
  - S0: o_data=top, o_en1=1, o_en2=0.
  - S1: o_data=mid, o_en1=1, o_en2=0.
  - S2: o_data=pix, o_en1=1, o_en2=1. In the same cycle, lb1[x]<=mid and lb0[x]<=pix.
  - IDLE: o_en1=0, o_en2=0, o_data holds its last value.
- Border rows, when y<2: rows outside the frame are substituted (see Optional Feature). Stale line-buffer contents never reach o_data.
- Counters:
  - x increments on each accept.
  - At x=IMG_W-1, x wraps to 0 and y increments.
  - At x=IMG_W-1 and y=IMG_H-1, both wrap to 0.
  - i_sof on an accepted pixel forces that pixel to x=0, y=0, overriding the counters, including mid-frame.
- Window tag:
  - tag = (x>=2 && y>=2) for the emitted column.
  - tag is shifted through a MED_LAT-deep register chain advanced only on o_en2.
  - o_med_valid = chain output. It is meaningful only while the filter is stable, i.e. between o_en2 pulses.
  - The chain is not advanced when no o_en2 occurs (stall-safe).
- o_frame_done pulses in the S2 cycle of the pixel at x=IMG_W-1, y=IMG_H-1.
- Reset values:
  - state=IDLE, x=0, y=0, o_data=0, o_en1=0, o_en2=0, tag chain=0, o_med_valid=0, o_frame_done=0.
  - o_ready=1 during the first cycle after reset release.
  - Line-buffer contents are not reset.
- Reset mid-column (S0/S1/S2): the latched pixel is discarded, no line-buffer write occurs, and o_en2 is not issued.
- Simultaneous accept in S2 with i_sof: the current column completes normally, and the new pixel starts at x=0, y=0.

Optional Feature:
- Macro: BORDER_REPLICATE_EN.
- Defined: missing rows are replicated from the nearest in-frame row.
  - y=0: top=mid=pix.
  - y=1: top=mid (the row-0 value).
- Undefined: missing rows are emitted as 8'h00.
- Columns x<2 are never altered; they are covered by the o_med_valid tag.

Test Plan:
- Reset, then one pixel 8'h55 with i_sof at x=0, y=0 (macro off) -> o_data sequence 00, 00, 55 over S0..S2; o_en1 high for 3 cycles; o_en2 only on the 3rd; o_ready low in S0/S1.
- Same stimulus with BORDER_REPLICATE_EN -> o_data 55, 55, 55.
- IMG_W=4, IMG_H=4, pixel value = 16*y+x, i_valid held high:
  - column at (2,2) emits 02, 12, 22;
  - o_med_valid first rises MED_LAT en2 pulses after that column;
  - o_med_valid is high for the 4 windows in total;
  - o_frame_done pulses once at (3,3).
- Back-to-back accept in S2 -> exactly 3 cycles per pixel and no idle gap; i_valid gaps -> FSM returns to IDLE; tag chain and o_med_valid hold.
- rst_n low during S1 of pixel (1,2), then restart with i_sof -> no o_en2 for the aborted pixel; counters restart at 0; the re-sent row produces the same columns as a clean run.
- i_sof asserted at x=2, y=1 -> that pixel is treated as (0,0): border substitution applies and the counters continue from x=1.
